uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Captures each received byte, together with its parity-error and frame-error flags, on the receiver's one-cycle done pulse.
- Holds entries until the game/command logic pops them.
- Decouples the bursty serial arrival rate from consumer processing.

Parameters:
- DATA_W, 8, width of the stored data byte.
- ADDR_W, 4, address width; depth = 2**ADDR_W entries (16).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  push strobe; connected to the receiver's rx_done_tick (one-cycle pulse).
- wr_data  in  DATA_W  received byte.
- wr_parity_err  in  1  parity-error flag accompanying wr_data.
- wr_frame_err  in  1  frame-error flag accompanying wr_data.
- rd_en  in  1  pop strobe from the consumer.
- rd_data  out  DATA_W  head entry data, first-word-fall-through.
- rd_parity_err  out  1  head entry parity flag.
- rd_frame_err  out  1  head entry frame flag.
- empty  out  1  no entries stored.
- full  out  1  2**ADDR_W entries stored.
- count  out  ADDR_W+1  number of stored entries.
- overflow  out  1  sticky: a push was lost.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Clock, reset and storage
  - All state updates on rising clk; reset sampled only at the clock edge.
  - Storage is an array of DATA_W+2 bits: {frame_err, parity_err, data}.
  - Write and read pointers are ADDR_W+1 bits. The MSB is a wrap bit.
  - full = (addresses equal) && (wrap bits differ). empty = pointers fully equal.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- Reset
  - Both pointers and overflow go to 0.
  - Outputs after reset: empty=1, full=0, count=0, overflow=0.
  - rd_data and the rd flags read as 0 while empty; the storage array itself is not reset.
  - A reset asserted mid-burst discards all entries. A wr_en in the same cycle as reset is ignored.
- Read path (FWFT)
  - When empty=0, rd_data and the rd flags show the head entry combinationally from storage.
  - rd_en advances rd_ptr at the next edge; the new head is visible in the following cycle.
  - rd_en while empty: ignored, no pointer change.
- Write path
  - wr_en while not full: writes the entry at wr_ptr and increments wr_ptr.
  - The entry is visible on the read side one cycle later (write-to-read latency = 1 cycle).
- Simultaneous wr_en and rd_en
  - Not empty and not full: both execute; count is unchanged.
  - Full: both execute. The pop frees a slot, so the write is accepted and no overflow occurs.
  - Empty: the write executes, the read is ignored; count becomes 1.
- Overflow
  - wr_en while full with no rd_en: the entry is dropped, pointers are unchanged, overflow is set to 1.
  - overflow stays set until clr_overflow is asserted.
  - Set and clear in the same cycle: set wins.
- Pointer wrap: pointers wrap naturally at 2**(ADDR_W+1); no special handling.
- Flag updates: count, empty and full are pure functions of the registered pointers, so each updates one cycle after the causing strobe.

Optional Feature:
- Macro: UART_RX_FIFO_ERR_DROP_EN.
- Defined:
  - A push with wr_frame_err=1 is discarded; pointers are unchanged.
  - It does not set overflow.
  - The frame-error bit is still kept in storage and on rd_frame_err, but always reads 0.
- Undefined: every wr_en push is stored regardless of its error flags.

Decomposition:
- Package uart_pkg holds:
  - DATA_W and default ADDR_W constants.
  - A typedef for the stored entry {frame_err, parity_err, data}.
  - Field-width localparams shared with the receiver and transmitter.
- Sub-module fifo_ctrl:
  - Owns pointers, full/empty/count generation and overflow.
  - Emits a write-enable and read/write addresses to a plain register-array storage in uart_rx_fifo.
  - Reusable for the transmit-side FIFO.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on separate cycles → count=3; rd_data=0x41 with empty=0 one cycle after the first push; three pops yield 0x41, 0x42, 0x43, then empty=1, count=0.
- Push 16 bytes 0x00..0x0F → full=1, count=16; 17th push 0xFF → dropped, overflow=1; pops return 0x00..0x0F only; clr_overflow → overflow=0.
- While full, assert wr_en (0xAA) and rd_en together → head 0x00 popped, 0xAA accepted, count stays 16, overflow stays 0; 0xAA is the last entry popped.
- While empty, assert wr_en (0x55) and rd_en together → count=1, rd_data=0x55; next cycle rd_en alone → empty=1.
- Push 0x10 with parity_err=1, then 0x20 with frame_err=1 → without the macro: both stored with correct rd flags; with UART_RX_FIFO_ERR_DROP_EN: only 0x10 stored, count=1, overflow=0.
- Fill with 5 entries, assert reset for one cycle with a simultaneous wr_en → empty=1, count=0, overflow=0 next cycle; 64 push/pop cycles afterwards verify pointer wrap with no data corruption.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-FIFO entry layout.
package uart_pkg;

    // Byte width and default receive-FIFO address width.
    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned UART_ADDR_W = 4;

    // Serial frame field widths shared with the receiver and transmitter.
    localparam int unsigned UART_START_BITS = 1;
    localparam int unsigned UART_PARITY_BITS = 1;
    localparam int unsigned UART_STOP_BITS = 1;
    localparam int unsigned UART_FRAME_BITS =
        UART_START_BITS + UART_DATA_W + UART_PARITY_BITS + UART_STOP_BITS;

    // One stored receive entry: {frame_err, parity_err, data}.
    typedef struct packed {
        logic                   frame_err;
        logic                   parity_err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    localparam int unsigned RX_ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a register-array FIFO. Owns the wrap-bit
// pointers, full/empty/count and the sticky overflow flag; the storage
// array lives in the instantiating module.
module fifo_ctrl #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              drop_i,
    input  logic              clr_overflow_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [ADDR_W-1:0] raddr_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o
);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            do_push, do_pop, ovf_set;

    // Flags are pure functions of the registered pointers.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign waddr_o    = wr_ptr_q[ADDR_W-1:0];
    assign raddr_o    = rd_ptr_q[ADDR_W-1:0];
    assign overflow_o = overflow_q;

    // Decide which strobes take effect; a pop on a full FIFO frees the slot.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && !drop_i && (!full_o || do_pop);
        ovf_set  = push_i && !drop_i && full_o && !do_pop;
        mem_we_o = do_push && !reset;
        wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, do_pop};
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Pointer and overflow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: first-word-fall-through FIFO of {frame_err,
// parity_err, data} entries captured on the receiver's done pulse.
// Build option UART_RX_FIFO_ERR_DROP_EN: pushes flagged with a frame error
// are discarded without touching the pointers or the overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned ADDR_W = UART_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_parity_err,
    input  logic              wr_frame_err,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_parity_err,
    output logic              rd_frame_err,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int unsigned EntryW = DATA_W + 2;
    localparam int unsigned Depth  = 2 ** ADDR_W;

    logic [EntryW-1:0] mem_q [Depth];
    logic [EntryW-1:0] head;
    logic              mem_we;
    logic              drop;
    logic [ADDR_W-1:0] waddr, raddr;

`ifdef UART_RX_FIFO_ERR_DROP_EN
    assign drop = wr_frame_err;
`else
    assign drop = 1'b0;
`endif

    fifo_ctrl #(
        .ADDR_W(ADDR_W)
    ) u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .push_i        (wr_en),
        .pop_i         (rd_en),
        .drop_i        (drop),
        .clr_overflow_i(clr_overflow),
        .mem_we_o      (mem_we),
        .waddr_o       (waddr),
        .raddr_o       (raddr),
        .empty_o       (empty),
        .full_o        (full),
        .count_o       (count),
        .overflow_o    (overflow)
    );

    // Storage array; deliberately not reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[waddr] <= {wr_frame_err, wr_parity_err, wr_data};
        end
    end

    // Head entry shown combinationally, forced to zero while empty.
    always_comb begin
        head = mem_q[raddr];
        if (empty) begin
            head = '0;
        end
        rd_data       = head[DATA_W-1:0];
        rd_parity_err = head[DATA_W];
        rd_frame_err  = head[DATA_W+1];
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with a queue scoreboard.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset, wr_en, wr_parity_err, wr_frame_err, rd_en, clr_overflow;
    logic [7:0] wr_data, rd_data;
    logic       rd_parity_err, rd_frame_err, empty, full, overflow;
    logic [4:0] count;

    logic [9:0] sb[$];
    logic       m_ovf;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_W(8),
        .ADDR_W(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_parity_err(wr_parity_err),
        .wr_frame_err (wr_frame_err),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_parity_err(rd_parity_err),
        .rd_frame_err (rd_frame_err),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // One clock of stimulus; the model is updated alongside.
    task automatic cycle(input logic w, input logic [7:0] d, input logic pe,
                         input logic fe, input logic r, input logic c);
        logic pop_ok, drop, set;
        wr_en = w; wr_data = d; wr_parity_err = pe; wr_frame_err = fe;
        rd_en = r; clr_overflow = c;
        pop_ok = r && (sb.size() != 0);
        drop = 1'b0;
`ifdef UART_RX_FIFO_ERR_DROP_EN
        drop = fe;
`endif
        set = 1'b0;
        if (pop_ok) void'(sb.pop_front());
        if (w && !drop) begin
            if (sb.size() < 16) sb.push_back({fe, pe, d});
            else set = 1'b1;
        end
        if (set) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0; clr_overflow = 0; wr_parity_err = 0; wr_frame_err = 0;
    endtask

    task automatic apply_reset(input logic w);
        reset = 1'b1; wr_en = w; wr_data = 8'hEE;
        @(posedge clk); #1;
        reset = 1'b0; wr_en = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset(1'b1);
        apply_reset(1'b0);
        n_vec++;
        if ({empty, full, count, overflow} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            $display("FAIL reset_flags: got e=%b f=%b c=%0d o=%b want e=1 f=0 c=0 o=0",
                     empty, full, count, overflow);
            n_err++;
        end
        n_vec++;
        if ({rd_frame_err, rd_parity_err, rd_data} !== 10'h000) begin
            $display("FAIL reset_rd: got %h want 000", {rd_frame_err, rd_parity_err, rd_data});
            n_err++;
        end
    endtask

    task automatic test_basic;
        logic [9:0] exp;
        cycle(1, 8'h41, 0, 0, 0, 0);
        n_vec++;
        if (empty !== 1'b0 || rd_data !== 8'h41) begin
            $display("FAIL fwft_latency: got e=%b d=%h want e=0 d=41", empty, rd_data);
            n_err++;
        end
        cycle(1, 8'h42, 0, 0, 0, 0);
        cycle(1, 8'h43, 0, 0, 0, 0);
        n_vec++;
        if (count !== 5'd3) begin
            $display("FAIL basic_count: got %0d want 3", count);
            n_err++;
        end
        for (int i = 0; i < 3; i++) begin
            exp = sb[0];
            n_vec++;
            if (rd_data !== exp[7:0]) begin
                $display("FAIL basic_pop%0d: got %h want %h", i, rd_data, exp[7:0]);
                n_err++;
            end
            cycle(0, 8'h00, 0, 0, 1, 0);
        end
        n_vec++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            $display("FAIL basic_drained: got e=%b c=%0d want e=1 c=0", empty, count);
            n_err++;
        end
    endtask

    task automatic test_overflow;
        logic [9:0] exp;
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0, 0, 0);
        n_vec++;
        if (full !== 1'b1 || count !== 5'd16) begin
            $display("FAIL full_flags: got f=%b c=%0d want f=1 c=16", full, count);
            n_err++;
        end
        cycle(1, 8'hFF, 0, 0, 0, 0);
        n_vec++;
        if (overflow !== m_ovf || count !== 5'd16) begin
            $display("FAIL overflow_set: got o=%b c=%0d want o=%b c=16", overflow, count, m_ovf);
            n_err++;
        end
        while (sb.size() != 0) begin
            exp = sb[0];
            n_vec++;
            if (rd_data !== exp[7:0]) begin
                $display("FAIL ovf_drain: got %h want %h", rd_data, exp[7:0]);
                n_err++;
            end
            cycle(0, 8'h00, 0, 0, 1, 0);
        end
        n_vec++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            $display("FAIL ovf_after_drain: got e=%b o=%b want e=1 o=1", empty, overflow);
            n_err++;
        end
        cycle(0, 8'h00, 0, 0, 0, 1);
        n_vec++;
        if (overflow !== m_ovf) begin
            $display("FAIL ovf_clear: got %b want %b", overflow, m_ovf);
            n_err++;
        end
    endtask

    task automatic test_full_rw;
        logic [9:0] exp;
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0, 0, 0);
        n_vec++;
        if (rd_data !== 8'h00) begin
            $display("FAIL full_rw_head: got %h want 00", rd_data);
            n_err++;
        end
        cycle(1, 8'hAA, 0, 0, 1, 0);
        n_vec++;
        if (count !== 5'd16 || overflow !== 1'b0 || rd_data !== 8'h01) begin
            $display("FAIL full_rw: got c=%0d o=%b d=%h want c=16 o=0 d=01",
                     count, overflow, rd_data);
            n_err++;
        end
        while (sb.size() != 0) begin
            exp = sb[0];
            n_vec++;
            if (rd_data !== exp[7:0]) begin
                $display("FAIL full_rw_drain: got %h want %h", rd_data, exp[7:0]);
                n_err++;
            end
            if (sb.size() == 1) begin
                n_vec++;
                if (rd_data !== 8'hAA) begin
                    $display("FAIL full_rw_last: got %h want aa", rd_data);
                    n_err++;
                end
            end
            cycle(0, 8'h00, 0, 0, 1, 0);
        end
    endtask

    task automatic test_empty_rw;
        cycle(1, 8'h55, 0, 0, 1, 0);
        n_vec++;
        if (count !== 5'd1 || rd_data !== 8'h55) begin
            $display("FAIL empty_rw: got c=%0d d=%h want c=1 d=55", count, rd_data);
            n_err++;
        end
        cycle(0, 8'h00, 0, 0, 1, 0);
        n_vec++;
        if (empty !== 1'b1) begin
            $display("FAIL empty_rw_pop: got e=%b want 1", empty);
            n_err++;
        end
    endtask

    task automatic test_err_flags;
        logic [9:0] exp;
        cycle(1, 8'h10, 1, 0, 0, 0);
        cycle(1, 8'h20, 0, 1, 0, 0);
        n_vec++;
        if (count !== 5'(sb.size()) || overflow !== 1'b0) begin
            $display("FAIL err_count: got c=%0d o=%b want c=%0d o=0", count, overflow, sb.size());
            n_err++;
        end
        while (sb.size() != 0) begin
            exp = sb[0];
            n_vec++;
            if ({rd_frame_err, rd_parity_err, rd_data} !== exp) begin
                $display("FAIL err_entry: got %h want %h",
                         {rd_frame_err, rd_parity_err, rd_data}, exp);
                n_err++;
            end
            cycle(0, 8'h00, 0, 0, 1, 0);
        end
    endtask

    task automatic test_reset_wrap;
        logic [9:0] exp;
        for (int i = 0; i < 5; i++) cycle(1, 8'hC0 + 8'(i), 0, 0, 0, 0);
        apply_reset(1'b1);
        n_vec++;
        if (empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0) begin
            $display("FAIL midburst_reset: got e=%b c=%0d o=%b want e=1 c=0 o=0",
                     empty, count, overflow);
            n_err++;
        end
        for (int i = 0; i < 64; i++) begin
            if (sb.size() >= 3) begin
                exp = sb[0];
                n_vec++;
                if ({rd_frame_err, rd_parity_err, rd_data} !== exp) begin
                    $display("FAIL wrap_data%0d: got %h want %h", i,
                             {rd_frame_err, rd_parity_err, rd_data}, exp);
                    n_err++;
                end
                cycle(1, 8'(i * 7 + 3), i[0], 0, 1, 0);
            end else begin
                cycle(1, 8'(i * 7 + 3), i[0], 0, 0, 0);
            end
            n_vec++;
            if (count !== 5'(sb.size())) begin
                $display("FAIL wrap_count%0d: got %0d want %0d", i, count, sb.size());
                n_err++;
            end
        end
        while (sb.size() != 0) begin
            exp = sb[0];
            n_vec++;
            if ({rd_frame_err, rd_parity_err, rd_data} !== exp) begin
                $display("FAIL wrap_drain: got %h want %h",
                         {rd_frame_err, rd_parity_err, rd_data}, exp);
                n_err++;
            end
            cycle(0, 8'h00, 0, 0, 1, 0);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 0; wr_data = 0; wr_parity_err = 0; wr_frame_err = 0;
        rd_en = 0; clr_overflow = 0; m_ovf = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_err_flags();
        test_reset_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
